// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Central stall/flush controller for the 5-stage pipeline.
//            It detects RAW data hazards between the ID-stage sources and the
//            EX/MEM destinations using Tuse/Tnew timing. It also models the
//            multi-cycle multiply/divide unit with a down-counter and stalls
//            ID-stage MD instructions while that unit is busy.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            d_rs/d_rt         - ID-stage source register addresses
//            d_tuse_rs/rt      - cycles until each source is needed (3 = unused)
//            d_is_md           - ID instruction uses the MD unit / HI / LO
//            e_regaddr/e_tnew  - EX-stage destination and its Tnew
//            m_regaddr/m_tnew  - MEM-stage destination and its Tnew
//            e_md_start/e_md_div - MD operation issued from EX (div qualifier)
//            stall, pc_en, fd_en, de_flush, em_en - pipeline control
//            md_busy           - MD unit busy
//            stall_cnt         - number of stalled cycles since reset
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_regaddr,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_regaddr,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        stall,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_flush,
  output logic        em_en,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] r_md_cnt;
  logic [31:0]      r_stall_cnt;
  logic             w_rs_hazard;
  logic             w_rt_hazard;
  logic             w_md_hazard;
  logic             w_stall;
  logic             w_md_busy;

  // EX and MEM matches are independent and ORed: a producer in either stage
  // whose result arrives later than the consumer needs it forces a stall.
  // A Tuse of 3 can never be below a 2-bit Tnew, so unused sources drop out.
  always_comb begin
    w_rs_hazard = 1'b0;
    w_rt_hazard = 1'b0;
    if (d_rs != 5'd0) begin
      w_rs_hazard = ((d_rs == e_regaddr) && (d_tuse_rs < e_tnew)) ||
                    ((d_rs == m_regaddr) && (d_tuse_rs < m_tnew));
    end
    if (d_rt != 5'd0) begin
      w_rt_hazard = ((d_rt == e_regaddr) && (d_tuse_rt < e_tnew)) ||
                    ((d_rt == m_regaddr) && (d_tuse_rt < m_tnew));
    end
  end

  assign w_md_busy   = (r_md_cnt != '0);
  // The issuing cycle itself also blocks an MD instruction, since the
  // counter only becomes nonzero on the following edge.
  assign w_md_hazard = d_is_md & (w_md_busy | e_md_start);
  assign w_stall     = w_rs_hazard | w_rt_hazard | w_md_hazard;

  // MD busy counter: a new start always reloads, even while busy, so a
  // stray back-to-back issue simply restarts the busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (e_md_start) begin
      r_md_cnt <= e_md_div ? c_div_load : c_mult_load;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  // Free-running 32-bit stall counter; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall     = w_stall;
  assign pc_en     = ~w_stall;
  assign fd_en     = ~w_stall;
  assign de_flush  = w_stall;
  assign em_en     = 1'b1;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed self-checking bench for hazard_stall_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt;
  logic [1:0]  d_tuse_rs, d_tuse_rt;
  logic        d_is_md;
  logic [4:0]  e_regaddr;
  logic [1:0]  e_tnew;
  logic [4:0]  m_regaddr;
  logic [1:0]  m_tnew;
  logic        e_md_start, e_md_div;
  logic        stall, pc_en, fd_en, de_flush, em_en, md_busy;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_is_md   (d_is_md),
    .e_regaddr (e_regaddr),
    .e_tnew    (e_tnew),
    .m_regaddr (m_regaddr),
    .m_tnew    (m_tnew),
    .e_md_start(e_md_start),
    .e_md_div  (e_md_div),
    .stall     (stall),
    .pc_en     (pc_en),
    .fd_en     (fd_en),
    .de_flush  (de_flush),
    .em_en     (em_en),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every stall-derived output against one expected stall value.
  task automatic chk_stall(input string tag, input logic exp);
    chk({tag, ".stall"},    {31'd0, stall},    {31'd0, exp});
    chk({tag, ".pc_en"},    {31'd0, pc_en},    {31'd0, ~exp});
    chk({tag, ".fd_en"},    {31'd0, fd_en},    {31'd0, ~exp});
    chk({tag, ".de_flush"}, {31'd0, de_flush}, {31'd0, exp});
    chk({tag, ".em_en"},    {31'd0, em_en},    32'd1);
  endtask

  task automatic clear_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; e_regaddr = 5'd0; e_tnew = 2'd0;
    m_regaddr = 5'd0; m_tnew = 2'd0; e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  // Advance one clock edge; inputs are then changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk_stall("rst", 1'b0);
    // Combinational hazard is visible during reset.
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_regaddr = 5'd5; e_tnew = 2'd1;
    #1 chk_stall("rst_hz", 1'b1);
    tick();
    chk("rst_hz.cnt", stall_cnt, 32'd0);
    reset = 1'b0;
    clear_inputs();
    #1;

    // --- rs vs EX ---
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_regaddr = 5'd5; e_tnew = 2'd1;
    #1 chk_stall("rs_ex", 1'b1);
    d_tuse_rs = 2'd1;
    #1 chk_stall("rs_ex_tuse_eq", 1'b0);
    d_tuse_rs = 2'd3; e_tnew = 2'd2;
    #1 chk_stall("rs_unused", 1'b0);

    // --- register 0 excluded ---
    clear_inputs();
    d_rt = 5'd0; e_regaddr = 5'd0; e_tnew = 2'd2; d_tuse_rt = 2'd0;
    #1 chk_stall("rt_zero", 1'b0);

    // --- rs vs MEM ---
    clear_inputs();
    d_rs = 5'd7; d_tuse_rs = 2'd0; m_regaddr = 5'd7; m_tnew = 2'd1; e_regaddr = 5'd3;
    #1 chk_stall("rs_mem", 1'b1);
    m_tnew = 2'd0;
    #1 chk_stall("rs_mem_ready", 1'b0);

    // --- rt vs EX and MEM ---
    clear_inputs();
    d_rt = 5'd9; d_tuse_rt = 2'd1; e_regaddr = 5'd9; e_tnew = 2'd2;
    #1 chk_stall("rt_ex", 1'b1);
    e_regaddr = 5'd4; m_regaddr = 5'd9; m_tnew = 2'd2;
    #1 chk_stall("rt_mem", 1'b1);
    m_regaddr = 5'd10;
    #1 chk_stall("rt_nomatch", 1'b0);
    // EX ready but MEM still pending: no priority, still stalls.
    clear_inputs();
    d_rs = 5'd12; d_tuse_rs = 2'd0; e_regaddr = 5'd12; e_tnew = 2'd0;
    m_regaddr = 5'd12; m_tnew = 2'd1;
    #1 chk_stall("rs_ex_and_mem", 1'b1);

    // --- mult busy window ---
    clear_inputs();
    tick();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b0;
    #1 chk_stall("mult.c0", 1'b1);
    chk("mult.c0.busy", {31'd0, md_busy}, 32'd0);
    tick();
    e_md_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1 chk("mult.busy", {31'd0, md_busy}, 32'd1);
      chk("mult.stall", {31'd0, stall}, 32'd1);
      tick();
    end
    #1 chk("mult.c6.busy", {31'd0, md_busy}, 32'd0);
    chk_stall("mult.c6", 1'b0);

    // --- div busy window ---
    e_md_start = 1'b1; e_md_div = 1'b1;
    #1 chk_stall("div.c0", 1'b1);
    tick();
    e_md_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1 chk("div.busy", {31'd0, md_busy}, 32'd1);
      chk("div.stall", {31'd0, stall}, 32'd1);
      tick();
    end
    #1 chk("div.c11.busy", {31'd0, md_busy}, 32'd0);
    chk_stall("div.c11", 1'b0);

    // --- reload while busy: mult, then div two cycles later ---
    d_is_md = 1'b0;
    e_md_start = 1'b1; e_md_div = 1'b0;
    tick();
    e_md_start = 1'b0;
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1;
    tick();
    e_md_start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #1 chk("reload.last", {31'd0, md_busy}, 32'd1);
    tick();
    #1 chk("reload.done", {31'd0, md_busy}, 32'd0);

    // --- stall counter ---
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("scnt.clr", stall_cnt, 32'd0);
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_regaddr = 5'd5; e_tnew = 2'd1;
    tick(); tick(); tick();
    clear_inputs();
    tick(); tick();
    #1 chk("scnt.3", stall_cnt, 32'd3);
    reset = 1'b1;
    d_is_md = 1'b1; e_md_start = 1'b1;  // ignored while in reset
    tick();
    e_md_start = 1'b0;
    #1 chk("scnt.rst", stall_cnt, 32'd0);
    chk("rst.md_ign", {31'd0, md_busy}, 32'd0);
    chk_stall("rst.md_ign", 1'b0);
    reset = 1'b0;
    clear_inputs();

    // --- reset in the middle of a divide ---
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
    tick();                         // now cycle 1
    e_md_start = 1'b0;
    tick(); tick(); tick();         // now cycle 4
    #1 chk("divrst.c4.busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    tick();                         // cycle 5
    reset = 1'b0;
    #1 chk("divrst.c5.busy", {31'd0, md_busy}, 32'd0);
    chk_stall("divrst.c5", 1'b0);
    tick();
    #1 chk("divrst.cnt", stall_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
